weight_plane_sequencer: RTL and testbench

WEIGHT_PLANE_SEQUENCER -- requirements
Module: weight_plane_sequencer

---
 rtl/weight_plane_sequencer.sv | 136 +++++++++++++
 tb/tb_weight_plane_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/weight_plane_sequencer.sv
// Bit-serial signed dot-product sequencer: issues weight bit-planes MSB first and accumulates returned partial sums.
// Latency: 2*W_BITS+1 cycles from start to done with zero-wait psum; each psum_valid stall adds one cycle per plane.
// Backpressure: waits indefinitely for psum_valid per plane; start ignored while busy. Optional EARLY_TERM_EN enables negative-result early exit.
module weight_plane_sequencer #(
    parameter int N_LANES = 32,
    parameter int W_BITS  = 8,
    parameter int PSUM_W  = 21,
    parameter int ACC_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [N_LANES*W_BITS-1:0]   weights,
    input  logic [PSUM_W-1:0]           psum_bound,
    output logic [N_LANES-1:0]          weight_bits,
    output logic                        plane_valid,
    input  logic [PSUM_W-1:0]           psum,
    input  logic                        psum_valid,
    output logic                        busy,
    output logic [ACC_W-1:0]            acc_out,
    output logic                        done,
    output logic                        terminated
);
    localparam int KW = (W_BITS > 1) ? $clog2(W_BITS) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(W_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                      state, state_nxt;
    logic [N_LANES*W_BITS-1:0]   w_reg;
    logic [KW-1:0]               k;
    logic [ACC_W-1:0]            acc;
    logic [ACC_W-1:0]            acc_upd;
    logic [ACC_W-1:0]            psum_ext;
    logic                        early_stop;
    logic                        finish_op;

    // The top plane carries the two's-complement sign weight, so it subtracts.
    assign psum_ext = ACC_W'(psum);
    assign acc_upd  = (k == K_TOP) ? ({acc[ACC_W-2:0], 1'b0} - psum_ext)
                                   : ({acc[ACC_W-2:0], 1'b0} + psum_ext);

`ifdef EARLY_TERM_EN
    localparam int EW = ACC_W + W_BITS;

    logic [PSUM_W-1:0] bound_reg;
    logic              term_q;
    logic [EW-1:0]     acc_wide;
    logic [EW-1:0]     plane_mask;
    logic [EW-1:0]     best_case;

    // Most optimistic final value: every remaining plane returns psum_bound.
    assign acc_wide   = {{W_BITS{acc_upd[ACC_W-1]}}, acc_upd};
    assign plane_mask = (EW'(1) << k) - EW'(1);
    assign best_case  = (acc_wide << k) + (EW'(bound_reg) * plane_mask);
    assign early_stop = (k != '0) && best_case[EW-1];
`else
    logic unused_bound;

    assign unused_bound = &{1'b0, psum_bound};
    assign early_stop   = 1'b0;
`endif

    assign finish_op = (k == '0) || early_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (psum_valid) state_nxt = finish_op ? S_DONE : S_ISSUE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_reg   <= '0;
            k       <= '0;
            acc     <= '0;
            acc_out <= '0;
`ifdef EARLY_TERM_EN
            bound_reg <= '0;
            term_q    <= 1'b0;
`endif
        end else begin
            if (state == S_IDLE && start) begin
                w_reg <= weights;
                acc   <= '0;
                k     <= K_TOP;
`ifdef EARLY_TERM_EN
                bound_reg <= psum_bound;
`endif
            end else if (state == S_WAIT && psum_valid) begin
                acc <= acc_upd;
                if (finish_op) begin
                    acc_out <= early_stop ? '0 : acc_upd;
`ifdef EARLY_TERM_EN
                    term_q  <= early_stop;
`endif
                end else begin
                    k <= k - KW'(1);
                end
            end
        end
    end

    always_comb begin
        weight_bits = '0;
        plane_valid = 1'b0;
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        if (state == S_ISSUE || state == S_WAIT) begin
            for (int i = 0; i < N_LANES; i++) begin
                weight_bits[i] = w_reg[i*W_BITS + int'(k)];
            end
        end
        if (state == S_ISSUE) plane_valid = 1'b1;
    end

`ifdef EARLY_TERM_EN
    assign terminated = (state == S_DONE) && term_q;
`else
    assign terminated = 1'b0;
`endif

endmodule

// File: tb/tb_weight_plane_sequencer.sv
// Directed bench for weight_plane_sequencer; a reactive psum responder models the AND array and its latency.
module tb_weight_plane_sequencer;
    localparam int N  = 32;
    localparam int W  = 8;
    localparam int PW = 21;
    localparam int AW = 32;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [N*W-1:0]  weights;
    logic [PW-1:0]   psum_bound;
    logic [N-1:0]    weight_bits;
    logic            plane_valid;
    logic [PW-1:0]   psum;
    logic            psum_valid;
    logic            busy;
    logic [AW-1:0]   acc_out;
    logic            done;
    logic            terminated;

    int n_tests = 0;
    int n_fail  = 0;

    int             act [N];
    logic [N*W-1:0] wvec;
    int             delay;
    int             exp_k;
    int             planes;
    bit             pending;
    int             cnt;
    logic [N-1:0]   held;

    weight_plane_sequencer #(.N_LANES(N), .W_BITS(W), .PSUM_W(PW), .ACC_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .weights(weights),
        .psum_bound(psum_bound), .weight_bits(weight_bits), .plane_valid(plane_valid),
        .psum(psum), .psum_valid(psum_valid), .busy(busy), .acc_out(acc_out),
        .done(done), .terminated(terminated)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] plane_of(input logic [N*W-1:0] w, input int k);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i] = w[i*W + k];
        return r;
    endfunction

    function automatic logic [PW-1:0] calc_psum(input logic [N-1:0] b);
        int s;
        s = 0;
        for (int i = 0; i < N; i++) if (b[i]) s += act[i];
        return PW'(s);
    endfunction

    // Responder: checks each issued plane, holds it for `delay` WAIT cycles, then returns psum.
    initial begin
        psum_valid = 1'b0;
        psum       = '0;
        pending    = 1'b0;
        cnt        = 0;
        held       = '0;
        forever begin
            @(negedge clk);
            psum_valid = 1'b0;
            if (!rst_n) begin
                pending = 1'b0;
            end else if (plane_valid) begin
                check("plane_bits", longint'(weight_bits), longint'(plane_of(wvec, exp_k)));
                held    = weight_bits;
                exp_k--;
                planes++;
                pending = 1'b1;
                cnt     = delay;
            end else if (pending) begin
                check("wait_stable", longint'(weight_bits), longint'(held));
                if (cnt == 0) begin
                    psum       = calc_psum(weight_bits);
                    psum_valid = 1'b1;
                    pending    = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic set_acts(input int v);
        for (int i = 0; i < N; i++) act[i] = v;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wbits"}, longint'(weight_bits), 0);
        check({tag, "_pvld"}, longint'(plane_valid), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_acc"}, longint'($signed(acc_out)), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_term"}, longint'(terminated), 0);
    endtask

    task automatic run_op(input string tag, input logic [N*W-1:0] w, input logic [PW-1:0] bnd,
                          input int dly, input bit hold, input longint exp_acc,
                          input int exp_cyc, input int exp_term, input int exp_planes);
        int cyc;
        int ndone;
        bit seen;
        cyc   = 0;
        ndone = 0;
        seen  = 1'b0;
        wvec  = w;
        delay = dly;
        exp_k = W - 1;
        planes = 0;
        weights    = w;
        psum_bound = bnd;
        start      = 1'b1;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                ndone++;
                check({tag, "_cycle"}, cyc, exp_cyc);
                check({tag, "_acc"}, longint'($signed(acc_out)), exp_acc);
                check({tag, "_term"}, longint'(terminated), exp_term);
            end
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
        @(negedge clk);
        start = 1'b0;
        if (done) ndone++;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check({tag, "_ndone"}, ndone, 1);
        check({tag, "_planes"}, planes, exp_planes);
        check({tag, "_busy_end"}, longint'(busy), 0);
        check({tag, "_acc_held"}, longint'($signed(acc_out)), exp_acc);
    endtask

    initial begin
        logic [N*W-1:0] mixed;
        rst_n      = 1'b1;
        start      = 1'b0;
        weights    = '0;
        psum_bound = '0;
        wvec       = '0;
        delay      = 0;
        exp_k      = W - 1;
        planes     = 0;
        set_acts(0);

        #3 rst_n = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        set_acts(3);
        run_op("w01_a3", {N{8'h01}}, PW'(96), 0, 1'b0, 96, 17, 0, 8);

        set_acts(1);
`ifdef EARLY_TERM_EN
        run_op("wff_a1", {N{8'hFF}}, PW'(32), 0, 1'b0, 0, 3, 1, 1);
`else
        run_op("wff_a1", {N{8'hFF}}, PW'(32), 0, 1'b0, -32, 17, 0, 8);
`endif

        set_acts(100);
`ifdef EARLY_TERM_EN
        run_op("w80_a100", {N{8'h80}}, PW'(3200), 0, 1'b0, 0, 3, 1, 1);
`else
        run_op("w80_a100", {N{8'h80}}, PW'(3200), 0, 1'b0, -409600, 17, 0, 8);
`endif

        // Lanes 0..3 carry 5, -3, 127, -128; remaining lanes have zero weight.
        mixed = '0;
        mixed[0*W +: W] = 8'h05;
        mixed[1*W +: W] = 8'hFD;
        mixed[2*W +: W] = 8'h7F;
        mixed[3*W +: W] = 8'h80;
        set_acts(7);
        act[0] = 10;
        act[1] = 20;
        act[2] = 1;
        act[3] = 2;
`ifdef EARLY_TERM_EN
        run_op("mixed_d0", mixed, PW'(33), 0, 1'b0, 0, 11, 1, 5);
        run_op("mixed_d3", mixed, PW'(33), 3, 1'b0, 0, 26, 1, 5);
`else
        run_op("mixed_d0", mixed, PW'(33), 0, 1'b0, -139, 17, 0, 8);
        run_op("mixed_d3", mixed, PW'(33), 3, 1'b0, -139, 41, 0, 8);
`endif

        // Abort an in-flight operation with reset at cycle 6.
        set_acts(3);
        wvec       = {N{8'h01}};
        weights    = wvec;
        psum_bound = PW'(96);
        delay      = 0;
        exp_k      = W - 1;
        planes     = 0;
        start      = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("midrun_busy", longint'(busy), 1);
        rst_n = 1'b0;
        #1 check_idle_outputs("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_reset", {N{8'h01}}, PW'(96), 0, 1'b0, 96, 17, 0, 8);

        run_op("start_held", {N{8'h01}}, PW'(96), 0, 1'b1, 96, 17, 0, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
